cc_fill_seq: RTL and testbench

// - Write-side sequencer for the combined instruction cache (cc_comb). Accepts whole 1040-bit lines from L2 refill,

---
 rtl/cc_fill_pkg.sv | 28 ++
 rtl/cc_fill_fifo.sv | 80 ++++++++
 rtl/cc_fill_seq.sv | 172 +++++++++++++++++
 tb/tb_cc_fill_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_fill_pkg.sv
// Shared widths, line layout and FSM encoding for the cc_comb fill sequencer.
package cc_fill_pkg;

    localparam int IP_W     = 44;
    localparam int LINE_W   = 1040;
    localparam int HALF_W   = 520;
    localparam int EXP_W    = 37;
    localparam int LINE_OFF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        INV   = 2'd3
    } fill_state_t;

    // Offset bits of the line address are never stored; they are always zero at the cache.
    typedef struct packed {
        logic [IP_W-LINE_OFF-1:0] ip_hi;
        logic [LINE_W-1:0]        data;
    } fill_line_t;

    // Clear the within-line offset bits of an address.
    function automatic logic [IP_W-1:0] line_align(input logic [IP_W-1:0] ip);
        return {ip[IP_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
    endfunction

endpackage

// File: rtl/cc_fill_fifo.sv
// Synchronous FIFO with registered count/full/empty, used for the line buffer
// and the eviction queue. Head is read straight from the storage array.
// A push while full is accepted only when a pop happens in the same cycle.
module cc_fill_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty_reg;
    assign do_push = push && (!full_reg || do_pop);

    assign head  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
    assign count = count_reg;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally at the power-of-two depth; flags registered from the next count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == FULL_CNT);
            empty_reg <= (count_next == '0);
        end
    end

endmodule

// File: rtl/cc_fill_seq.sv
// Write-side sequencer for cc_comb: buffers L2 refill lines, writes them as two
// half-line beats, issues single-cycle invalidates and queues victims for L2.
// Optional feature macro: CC_FILL_INV_EN enables the invalidate path.
// rst is asynchronous and active-low.
module cc_fill_seq
    import cc_fill_pkg::*;
#(
    parameter int FILL_DEPTH = 2,
    parameter int EVQ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [IP_W-1:0]   fill_IP,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              inv_valid,
    output logic              inv_ready,
    input  logic [IP_W-1:0]   inv_IP,
    output logic [IP_W-1:0]   write_IP,
    output logic              cc_write_wen,
    output logic              cc_invalidate,
    output logic [HALF_W-1:0] write_data,
    input  logic              expun_wen,
    input  logic [EXP_W-1:0]  expun_addr,
    output logic              evict_valid,
    input  logic              evict_ready,
    output logic [EXP_W-1:0]  evict_addr
);

    localparam int FW = $clog2(FILL_DEPTH);
    localparam int EW = $clog2(EVQ_DEPTH);
    // A fill may start only while two victim slots remain: one for the line in flight, one spare.
    localparam logic [EW:0] EVQ_ROOM_MAX = (EW+1)'(EVQ_DEPTH - 2);

    fill_state_t state_reg;
    fill_state_t state_next;

    fill_line_t  fill_in;
    fill_line_t  fill_head;
    logic        fill_full;
    logic        fill_empty;
    logic        fill_pop;
    logic [FW:0] unused_fill_count;

    logic [EXP_W-1:0] evq_head;
    logic             evq_full;
    logic             evq_empty;
    logic             evq_pop;
    logic [EW:0]      evq_count;
    logic             evq_room;

    logic              inv_take;
    logic              wen_reg;
    logic              invalidate_reg;
    logic [IP_W-1:0]   write_ip_reg;
    logic [HALF_W-1:0] write_data_reg;

    assign fill_in.ip_hi = fill_IP[IP_W-1:LINE_OFF];
    assign fill_in.data  = fill_data;
    assign fill_ready    = !fill_full;
    assign fill_pop      = (state_reg == BEAT1);

    cc_fill_fifo #(
        .W     ($bits(fill_line_t)),
        .DEPTH (FILL_DEPTH)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (fill_valid && !fill_full),
        .push_data (fill_in),
        .pop       (fill_pop),
        .head      (fill_head),
        .full      (fill_full),
        .empty     (fill_empty),
        .count     (unused_fill_count)
    );

    assign evict_valid = !evq_empty;
    assign evict_addr  = evq_empty ? '0 : evq_head;
    assign evq_pop     = evict_valid && evict_ready;
    assign evq_room    = (evq_count <= EVQ_ROOM_MAX);

    cc_fill_fifo #(
        .W     (EXP_W),
        .DEPTH (EVQ_DEPTH)
    ) u_evict_q (
        .clk       (clk),
        .rst       (rst),
        .push      (expun_wen),
        .push_data (expun_addr),
        .pop       (evq_pop),
        .head      (evq_head),
        .full      (evq_full),
        .empty     (evq_empty),
        .count     (evq_count)
    );

    // A victim arriving with the queue full and no pop would be lost.
    assert property (@(posedge clk) disable iff (!rst) !(expun_wen && evq_full && !evq_pop));

`ifdef CC_FILL_INV_EN
    assign inv_take = (state_reg == IDLE) && inv_valid;
`else
    logic unused_inv;
    assign inv_take   = 1'b0;
    assign unused_inv = ^{inv_valid, inv_IP};
`endif

    assign inv_ready     = inv_take;
    assign cc_write_wen  = wen_reg;
    assign cc_invalidate = invalidate_reg;
    assign write_IP      = write_ip_reg;
    assign write_data    = write_data_reg;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Invalidates win over pending fills; the two beats of a fill are never split.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (inv_take) begin
                    state_next = INV;
                end else if (!fill_empty && evq_room) begin
                    state_next = BEAT0;
                end
            end
            BEAT0:   state_next = BEAT1;
            BEAT1:   state_next = IDLE;
            INV:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered cache-port outputs driven from the state being entered; address/data hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_reg        <= 1'b0;
            invalidate_reg <= 1'b0;
            write_ip_reg   <= '0;
            write_data_reg <= '0;
        end else begin
            wen_reg        <= (state_next == BEAT0);
            invalidate_reg <= (state_next == INV);
            case (state_next)
                BEAT0: begin
                    write_ip_reg   <= {fill_head.ip_hi, {LINE_OFF{1'b0}}};
                    write_data_reg <= fill_head.data[HALF_W-1:0];
                end
                BEAT1: begin
                    write_data_reg <= fill_head.data[LINE_W-1:HALF_W];
                end
`ifdef CC_FILL_INV_EN
                INV: begin
                    write_ip_reg <= line_align(inv_IP);
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_fill_seq.sv
// Self-checking bench for cc_fill_seq: a cycle-timeline model of fills,
// invalidates and the eviction queue is compared every cycle, plus directed
// scenarios with literal expectations. Honours CC_FILL_INV_EN.
module tb_cc_fill_seq;
    import cc_fill_pkg::*;

    localparam int FILL_DEPTH = 2;
    localparam int EVQ_DEPTH  = 4;
`ifdef CC_FILL_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    typedef logic [519:0] w_t;
    typedef struct {
        logic [43:0]   ip;
        logic [1039:0] data;
    } line_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          fill_valid;
    logic          fill_ready;
    logic [43:0]   fill_IP;
    logic [1039:0] fill_data;
    logic          inv_valid;
    logic          inv_ready;
    logic [43:0]   inv_IP;
    logic [43:0]   write_IP;
    logic          cc_write_wen;
    logic          cc_invalidate;
    logic [519:0]  write_data;
    logic          expun_wen;
    logic [36:0]   expun_addr;
    logic          evict_valid;
    logic          evict_ready;
    logic [36:0]   evict_addr;

    cc_fill_seq #(
        .FILL_DEPTH (FILL_DEPTH),
        .EVQ_DEPTH  (EVQ_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_IP       (fill_IP),
        .fill_data     (fill_data),
        .inv_valid     (inv_valid),
        .inv_ready     (inv_ready),
        .inv_IP        (inv_IP),
        .write_IP      (write_IP),
        .cc_write_wen  (cc_write_wen),
        .cc_invalidate (cc_invalidate),
        .write_data    (write_data),
        .expun_wen     (expun_wen),
        .expun_addr    (expun_addr),
        .evict_valid   (evict_valid),
        .evict_ready   (evict_ready),
        .evict_addr    (evict_addr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input w_t got, input w_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    line_t       fq[$];
    logic [36:0] eq[$];
    line_t       cur;
    int          cyc     = 0;
    int          free_at = 0;
    int          high_at = -1;
    int          pop_at  = -1;
    logic        e_wen   = 1'b0;
    logic        e_inv   = 1'b0;
    logic [43:0] e_ip    = '0;
    logic [519:0] e_data = '0;

    int          wen_cyc[$];
    logic [519:0] wen_low[$];
    bit          saw_not_ready = 1'b0;

    // Inputs change only just after posedge, so at negedge they are what the next edge samples.
    always @(negedge clk) begin
        bit          x_ready;
        bit          x_inv_take;
        bit          x_fill_take;
        logic [36:0] x_eaddr;
        if (!rst) begin
            fq.delete();
            eq.delete();
            free_at = 0;
            high_at = -1;
            pop_at  = -1;
            e_wen   = 1'b0;
            e_inv   = 1'b0;
            e_ip    = '0;
            e_data  = '0;
        end
        x_ready    = (fq.size() < FILL_DEPTH);
        x_inv_take = INV_EN && inv_valid && (cyc >= free_at);
        x_eaddr    = (eq.size() > 0) ? eq[0] : 37'h0;
        check($sformatf("model_fill_ready@%0d", cyc), w_t'(fill_ready), w_t'(x_ready));
        check($sformatf("model_inv_ready@%0d", cyc), w_t'(inv_ready), w_t'(x_inv_take));
        check($sformatf("model_wen@%0d", cyc), w_t'(cc_write_wen), w_t'(e_wen));
        check($sformatf("model_invalidate@%0d", cyc), w_t'(cc_invalidate), w_t'(e_inv));
        check($sformatf("model_write_IP@%0d", cyc), w_t'(write_IP), w_t'(e_ip));
        check($sformatf("model_write_data@%0d", cyc), write_data, e_data);
        check($sformatf("model_evict_valid@%0d", cyc), w_t'(evict_valid), w_t'(eq.size() > 0));
        check($sformatf("model_evict_addr@%0d", cyc), w_t'(evict_addr), w_t'(x_eaddr));
        if (rst && cc_write_wen) begin
            wen_cyc.push_back(cyc);
            wen_low.push_back(write_data);
        end
        if (rst && !fill_ready) saw_not_ready = 1'b1;
        if (rst) begin
            x_fill_take = !x_inv_take && (cyc >= free_at) && (fq.size() > 0)
                          && (eq.size() <= EVQ_DEPTH - 2);
            e_wen = 1'b0;
            e_inv = 1'b0;
            if (cyc == high_at) e_data = cur.data[1039:520];
            if (x_inv_take) begin
                e_inv   = 1'b1;
                e_ip    = {inv_IP[43:5], 5'b0};
                free_at = cyc + 2;
            end
            if (x_fill_take) begin
                cur     = fq[0];
                e_wen   = 1'b1;
                e_ip    = {cur.ip[43:5], 5'b0};
                e_data  = cur.data[519:0];
                high_at = cyc + 1;
                pop_at  = cyc + 2;
                free_at = cyc + 3;
            end
            if (cyc == pop_at) void'(fq.pop_front());
            if (fill_valid && x_ready) fq.push_back('{fill_IP, fill_data});
            if (evict_ready && eq.size() > 0) void'(eq.pop_front());
            if (expun_wen) eq.push_back(expun_addr);
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_fill(input logic [43:0] ip, input logic [519:0] lo, input logic [519:0] hi);
        int waited = 0;
        fill_valid = 1'b1;
        fill_IP    = ip;
        fill_data  = {hi, lo};
        while (!fill_ready && waited < 20) begin
            step(1);
            waited++;
        end
        check("fill_accept_wait", w_t'(fill_ready), w_t'(1'b1));
        step(1);
        fill_valid = 1'b0;
        $display("[TB] fill ip=%h accepted", ip);
    endtask

    logic [519:0] lo_a, hi_a, lo_b, hi_b, lo_c, hi_c;

    initial begin
        rst = 1'b0; fill_valid = 1'b0; fill_IP = '0; fill_data = '0;
        inv_valid = 1'b0; inv_IP = '0; expun_wen = 1'b0; expun_addr = '0; evict_ready = 1'b0;
        lo_a = {65{8'h5A}}; hi_a = {65{8'hA5}};
        lo_b = {65{8'h11}}; hi_b = {65{8'h22}};
        lo_c = {65{8'h33}}; hi_c = {65{8'h44}};

        // reset values
        step(3);
        check("rst_fill_ready", w_t'(fill_ready), w_t'(1'b1));
        check("rst_wen", w_t'(cc_write_wen), w_t'(1'b0));
        check("rst_invalidate", w_t'(cc_invalidate), w_t'(1'b0));
        check("rst_write_IP", w_t'(write_IP), w_t'(44'h0));
        check("rst_write_data", write_data, w_t'(0));
        check("rst_evict_valid", w_t'(evict_valid), w_t'(1'b0));
        check("rst_evict_addr", w_t'(evict_addr), w_t'(37'h0));
        $display("[TB] reset released");
        rst = 1'b1;
        step(2);

        // single fill
        send_fill(44'h123_4567_89A0, {65{8'h5A}}, {65{8'hA5}});
        step(1);
        check("t1_beat0_wen", w_t'(cc_write_wen), w_t'(1'b1));
        check("t1_beat0_data", write_data, {65{8'h5A}});
        check("t1_beat0_ip", w_t'(write_IP), w_t'(44'h123_4567_89A0));
        check("t1_beat0_ready", w_t'(fill_ready), w_t'(1'b1));
        step(1);
        check("t1_beat1_wen", w_t'(cc_write_wen), w_t'(1'b0));
        check("t1_beat1_data", write_data, {65{8'hA5}});
        check("t1_beat1_ip", w_t'(write_IP), w_t'(44'h123_4567_89A0));
        check("t1_beat1_ready", w_t'(fill_ready), w_t'(1'b1));
        step(2);

        // three back-to-back fills into a two-entry buffer
        wen_cyc.delete(); wen_low.delete(); saw_not_ready = 1'b0;
        send_fill(44'hAAA_0000_001F, lo_a, hi_a);
        send_fill(44'hBBB_0000_0021, lo_b, hi_b);
        send_fill(44'hCCC_0000_0045, lo_c, hi_c);
        step(10);
        check("t2_pulse_count", w_t'(wen_cyc.size()), w_t'(3));
        check("t2_ready_dropped", w_t'(saw_not_ready), w_t'(1'b1));
        if (wen_cyc.size() == 3) begin
            check("t2_gap01", w_t'(wen_cyc[1] - wen_cyc[0]), w_t'(3));
            check("t2_gap12", w_t'(wen_cyc[2] - wen_cyc[1]), w_t'(3));
            check("t2_order0", wen_low[0], lo_a);
            check("t2_order1", wen_low[1], lo_b);
            check("t2_order2", wen_low[2], lo_c);
        end

`ifdef CC_FILL_INV_EN
        // invalidate and fill in the same cycle; invalidate during BEAT0 waits
        inv_IP = 44'hDEF_0123_4567; inv_valid = 1'b1;
        fill_IP = 44'h777_0000_0000; fill_data = {hi_b, lo_b}; fill_valid = 1'b1;
        #1;
        check("t3_inv_ready", w_t'(inv_ready), w_t'(1'b1));
        step(1);
        inv_valid = 1'b0; fill_valid = 1'b0;
        $display("[TB] invalidate ip=%h with fill ip=777_0000_0000", 44'hDEF_0123_4567);
        check("t3_invalidate", w_t'(cc_invalidate), w_t'(1'b1));
        check("t3_inv_ip", w_t'(write_IP), w_t'(44'hDEF_0123_4560));
        check("t3_inv_no_wen", w_t'(cc_write_wen), w_t'(1'b0));
        step(1);
        check("t3_idle_invalidate", w_t'(cc_invalidate), w_t'(1'b0));
        check("t3_idle_wen", w_t'(cc_write_wen), w_t'(1'b0));
        step(1);
        check("t3_fill_wen", w_t'(cc_write_wen), w_t'(1'b1));
        check("t3_fill_data", write_data, lo_b);
        inv_IP = 44'h555_5555_555F; inv_valid = 1'b1;
        #1;
        check("t3_beat0_inv_ready", w_t'(inv_ready), w_t'(1'b0));
        step(1);
        check("t3_beat1_inv_ready", w_t'(inv_ready), w_t'(1'b0));
        check("t3_beat1_invalidate", w_t'(cc_invalidate), w_t'(1'b0));
        step(1);
        check("t3_late_inv_ready", w_t'(inv_ready), w_t'(1'b1));
        step(1);
        inv_valid = 1'b0;
        $display("[TB] invalidate ip=%h after beat pair", 44'h555_5555_555F);
        check("t3_late_invalidate", w_t'(cc_invalidate), w_t'(1'b1));
        check("t3_late_ip", w_t'(write_IP), w_t'(44'h555_5555_5540));
        step(2);
`else
        // invalidate path absent: requests are ignored, fills proceed
        inv_IP = 44'hDEF_0123_4567; inv_valid = 1'b1;
        send_fill(44'h777_0000_0000, lo_b, hi_b);
        check("t3_off_inv_ready0", w_t'(inv_ready), w_t'(1'b0));
        step(1);
        check("t3_off_wen", w_t'(cc_write_wen), w_t'(1'b1));
        check("t3_off_ip", w_t'(write_IP), w_t'(44'h777_0000_0000));
        check("t3_off_inv_ready1", w_t'(inv_ready), w_t'(1'b0));
        check("t3_off_invalidate", w_t'(cc_invalidate), w_t'(1'b0));
        step(1);
        check("t3_off_high", write_data, hi_b);
        check("t3_off_inv_ready2", w_t'(inv_ready), w_t'(1'b0));
        inv_valid = 1'b0;
        step(2);
`endif

        // eviction queue gating
        evict_ready = 1'b0;
        expun_wen = 1'b1; expun_addr = 37'h00_1111_1111; step(1);
        expun_addr = 37'h00_2222_2222; step(1);
        expun_addr = 37'h1F_3333_3333; step(1);
        expun_wen = 1'b0;
        $display("[TB] three victims queued");
        check("t4_evict_valid", w_t'(evict_valid), w_t'(1'b1));
        check("t4_evict_head", w_t'(evict_addr), w_t'(37'h00_1111_1111));
        wen_cyc.delete();
        send_fill(44'h999_0000_0000, lo_c, hi_c);
        step(4);
        check("t4_fill_held", w_t'(wen_cyc.size()), w_t'(0));
        evict_ready = 1'b1;
        step(1);
        evict_ready = 1'b0;
        $display("[TB] one victim returned");
        check("t4_evict_next", w_t'(evict_addr), w_t'(37'h00_2222_2222));
        step(1);
        check("t4_fill_started", w_t'(cc_write_wen), w_t'(1'b1));
        check("t4_fill_data", write_data, lo_c);
        evict_ready = 1'b1;
        step(2);
        evict_ready = 1'b0;
        check("t4_drained", w_t'(evict_valid), w_t'(1'b0));
        step(2);

        // reset during BEAT1
        expun_wen = 1'b1; expun_addr = 37'h0A_BCDE_F012; step(1);
        expun_wen = 1'b0;
        send_fill(44'h246_8ACE_0000, lo_a, hi_a);
        send_fill(44'h135_7913_0000, lo_b, hi_b);
        step(1);
        check("t5_beat1_wen", w_t'(cc_write_wen), w_t'(1'b0));
        check("t5_beat1_data", write_data, hi_a);
        rst = 1'b0;
        #1;
        $display("[TB] reset asserted during BEAT1");
        check("t5_rst_wen", w_t'(cc_write_wen), w_t'(1'b0));
        check("t5_rst_data", write_data, w_t'(0));
        check("t5_rst_ip", w_t'(write_IP), w_t'(44'h0));
        check("t5_rst_fill_ready", w_t'(fill_ready), w_t'(1'b1));
        check("t5_rst_evict_valid", w_t'(evict_valid), w_t'(1'b0));
        step(2);
        rst = 1'b1;
        wen_cyc.delete();
        step(8);
        check("t5_no_replay", w_t'(wen_cyc.size()), w_t'(0));
        check("t5_after_evict_valid", w_t'(evict_valid), w_t'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
